// File: rtl/mem_fill_responder.sv
// mem_fill_responder: owns the backing word array and streams 8-word
// cache line fills after a fixed latency; takes single-word writes when idle.
module mem_fill_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic        hold,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [2:0]  word_idx,
  output logic        fill_done
);

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    STREAM
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  lat_cnt, lat_cnt_nxt;
  logic [2:0]  wcnt, wcnt_nxt;
  logic [11:0] line, line_nxt;
  logic [11:0] rd_line;
  logic        emit;
  logic        accept;
  logic        wr_ok;

  logic [14:0]       rd_word;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [15:0]       rd_data;
  logic [15:0]       mem [2**ADDR_W];

  assign busy   = (state != IDLE) | data_valid;
  assign accept = ~busy & req_valid;
  assign wr_ok  = ~busy & wr_en;

  // Word address is (base>>1)+wcnt; a line never crosses
  // its 16-byte boundary, so the add reduces to a concat.
  assign rd_word = {rd_line, wcnt};
  assign rd_idx  = rd_word[ADDR_W-1:0];
  assign wr_idx  = wr_addr[ADDR_W:1];

  // Same-edge write forwarding only matters when word 0
  // is read on the acceptance edge (single-cycle latency).
  assign rd_data = (wr_ok && (wr_idx == rd_idx)) ?
                   wr_data : mem[rd_idx];

  assign fill_done = data_valid & (word_idx == 3'd7);

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    wcnt_nxt    = wcnt;
    line_nxt    = line;
    rd_line     = line;
    emit        = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          line_nxt    = req_addr[15:4];
          lat_cnt_nxt = LAT_INIT;
          wcnt_nxt    = 3'd0;
          if (LATENCY == 1) begin
            rd_line   = req_addr[15:4];
            emit      = 1'b1;
            wcnt_nxt  = 3'd1;
            state_nxt = STREAM;
          end else if (LATENCY == 2) begin
            state_nxt = STREAM;
          end else begin
            state_nxt = LAT;
          end
        end
      end
      LAT: begin
        lat_cnt_nxt = lat_cnt - 4'd1;
        if (lat_cnt <= 4'd2) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        lat_cnt_nxt = 4'd0;
        if (!hold) begin
          emit     = 1'b1;
          wcnt_nxt = wcnt + 3'd1;
          if (wcnt == 3'd7) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
      wcnt    <= 3'd0;
      line    <= 12'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      wcnt    <= wcnt_nxt;
      line    <= line_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
      data_out   <= 16'h0000;
      word_idx   <= 3'd0;
    end else begin
      data_valid <= emit;
      if (emit) begin
        data_out <= rd_data;
        word_idx <= wcnt;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{req_addr[3:0], wr_addr[0],
                         wr_addr[15:ADDR_W+1],
                         rd_word[14:ADDR_W]};

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed fills on a LATENCY=4 and a LATENCY=1
// instance sharing inputs; expected words and cycles are hand-derived.
module tb_mem_fill_responder;

  localparam int NCAP = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        hold;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  logic        a_busy, a_valid, a_done;
  logic [15:0] a_data;
  logic [2:0]  a_idx;
  logic        b_busy, b_valid, b_done;
  logic [15:0] b_data;
  logic [2:0]  b_idx;

  int n_checks = 0;
  int n_pass   = 0;

  logic        cap_v [NCAP];
  logic [15:0] cap_d [NCAP];
  logic [2:0]  cap_i [NCAP];
  logic        cap_b [NCAP];
  logic        cap_f [NCAP];

  always #5 clk = ~clk;

  mem_fill_responder #(.LATENCY(4), .ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(a_busy), .data_valid(a_valid),
    .data_out(a_data), .word_idx(a_idx),
    .fill_done(a_done)
  );

  mem_fill_responder #(.LATENCY(1), .ADDR_W(10)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(b_busy), .data_valid(b_valid),
    .data_out(b_data), .word_idx(b_idx),
    .fill_done(b_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle in which the request is driven.
  task automatic run_fill(input logic sel_b,
                          input logic [15:0] addr,
                          input logic [31:0] hold_mask,
                          input int wr_cyc,
                          input logic [15:0] waddr,
                          input logic [15:0] wdata,
                          input int rq2_cyc,
                          input logic [15:0] rq2_addr);
    for (int k = 0; k < NCAP; k++) begin
      req_valid = (k == 0) || (k == rq2_cyc);
      req_addr  = (k == 0) ? addr : rq2_addr;
      hold      = hold_mask[k];
      wr_en     = (k == wr_cyc);
      wr_addr   = waddr;
      wr_data   = wdata;
      @(negedge clk);
      cap_v[k] = sel_b ? b_valid : a_valid;
      cap_d[k] = sel_b ? b_data  : a_data;
      cap_i[k] = sel_b ? b_idx   : a_idx;
      cap_b[k] = sel_b ? b_busy  : a_busy;
      cap_f[k] = sel_b ? b_done  : a_done;
      tick();
    end
    req_valid = 1'b0;
    hold      = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic check_fill(input string tag,
                            input int cyc [8],
                            input logic [15:0] exp [8]);
    int np;
    int nd;
    np = 0;
    nd = 0;
    for (int k = 0; k < NCAP; k++) begin
      np += int'(cap_v[k]);
      nd += int'(cap_f[k]);
    end
    check({tag, "_pulses"}, np, 8);
    check({tag, "_done_cnt"}, nd, 1);
    check({tag, "_done_w7"}, cap_f[cyc[7]], 1);
    for (int w = 0; w < 8; w++) begin
      check($sformatf("%s_v%0d", tag, w), cap_v[cyc[w]], 1);
      check($sformatf("%s_d%0d", tag, w), cap_d[cyc[w]], exp[w]);
      check($sformatf("%s_i%0d", tag, w), cap_i[cyc[w]], w);
    end
  endtask

  int          c_a [8];
  int          c_h [8];
  int          c_b [8];
  logic [15:0] e_l [8];
  logic [15:0] e_w [8];
  logic [15:0] e_x [8];
  int          np;

  initial begin
    c_a = '{4, 5, 6, 7, 8, 9, 10, 11};
    c_h = '{4, 5, 8, 9, 10, 11, 12, 13};
    c_b = '{1, 2, 3, 4, 5, 6, 7, 8};
    for (int i = 0; i < 8; i++) begin
      e_l[i] = 16'h1000 + 16'(i);
      e_x[i] = 16'h2000 + 16'(i);
    end
    e_w    = e_l;
    e_w[2] = 16'hBEEF;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0;
    hold      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 16'h0;
    wr_data   = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 16'h0000);
    check("rst_idx", a_idx, 0);
    check("rst_done", a_done, 0);
    check("rst_b_busy", b_busy, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 16'h0020 + 16'(2 * i);
      wr_data = 16'h1000 + 16'(i);
      tick();
      wr_addr = 16'h0010 + 16'(2 * i);
      wr_data = 16'h2000 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();

    run_fill(1'b0, 16'h0026, 32'h0, -1, 16'h0, 16'h0, -1, 16'h0);
    check_fill("plain", c_a, e_l);
    check("busy_c0", cap_b[0], 0);
    check("busy_c1", cap_b[1], 1);
    check("busy_c11", cap_b[11], 1);
    check("busy_c12", cap_b[12], 0);
    check("valid_c3", cap_v[3], 0);
    check("done_c10", cap_f[10], 0);

    run_fill(1'b0, 16'h0026, 32'h60, -1, 16'h0, 16'h0, -1, 16'h0);
    check_fill("hold", c_h, e_l);
    check("hold_gap6", cap_v[6], 0);
    check("hold_gap7", cap_v[7], 0);
    check("hold_busy13", cap_b[13], 1);
    check("hold_busy14", cap_b[14], 0);

    run_fill(1'b0, 16'h0020, 32'h0, 0, 16'h0024, 16'hBEEF, -1, 16'h0);
    check_fill("wr_req", c_a, e_w);

    run_fill(1'b0, 16'h0020, 32'h0, 2, 16'h0022, 16'hDEAD, 3, 16'h0040);
    check_fill("busy_drop", c_a, e_w);

    req_valid = 1'b1;
    req_addr  = 16'h0020;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("pre_rst_valid", a_valid, 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", a_valid, 0);
    check("async_busy", a_busy, 0);
    check("async_data", a_data, 16'h0000);
    tick();
    rst = 1'b0;
    np = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      np += int'(a_valid);
      tick();
    end
    check("post_rst_pulses", np, 0);

    run_fill(1'b0, 16'h0020, 32'h0, -1, 16'h0, 16'h0, -1, 16'h0);
    check_fill("after_rst", c_a, e_w);

    run_fill(1'b1, 16'h0810, 32'h0, -1, 16'h0, 16'h0, -1, 16'h0);
    check_fill("alias_hi", c_b, e_x);
    check("lat1_c0", cap_v[0], 0);
    run_fill(1'b1, 16'h0010, 32'h0, -1, 16'h0, 16'h0, -1, 16'h0);
    check_fill("alias_lo", c_b, e_x);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
